// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared FSM encoding and data widths for the MEM-stage LSU
package lsu_pkg;

   localparam int BYTE_W = 8;
   localparam int WORD_W = 2 * BYTE_W;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HI   = 2'd1,
      ST_LO   = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM-stage LSU serialising 8/16-bit big-endian accesses onto a byte memory; LSU_RANGE_CHECK_EN adds a range fault
module mem_stage_lsu
   import lsu_pkg::*;
#(
   parameter int N  = 100,
   parameter int AW = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_word,
   input  logic [AW-1:0]     req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [WORD_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              busy,
   output logic [AW-1:0]     mem_addr,
   output logic              mem_re,
   output logic              mem_we,
   output logic [BYTE_W-1:0] mem_wdata,
   input  logic [BYTE_W-1:0] mem_rdata
);

   localparam logic [31:0] N_LIM = 32'(N);

   lsu_state_e        state_q, state_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [WORD_W-1:0] wdata_q, wdata_d;
   logic              write_q, write_d;
   logic              word_q, word_d;
   logic              err_q, err_d;
   logic [BYTE_W-1:0] hi_q, hi_d;
   logic [WORD_W-1:0] rdata_q, rdata_d;

   logic [AW-1:0]     addr_inc;
   logic [AW-1:0]     req_addr_inc;
   logic              addr_oob;
   logic              req_fault;
   logic [WORD_W-1:0] done_rdata;

   // The second byte of a word sits at A+1, wrapping at the top of the address space
   assign addr_inc     = addr_q + AW'(1);
   assign req_addr_inc = req_addr + AW'(1);

   // Out-of-range test on the incoming request, covering both bytes of a word
   always_comb begin
      addr_oob = (32'(req_addr) >= N_LIM);
      if (req_word && (32'(req_addr_inc) >= N_LIM)) begin
         addr_oob = 1'b1;
      end
   end

`ifdef LSU_RANGE_CHECK_EN
   assign req_fault = addr_oob;
   assign rsp_err   = (state_q == ST_DONE) && err_q;
`else
   logic unused_range;
   assign req_fault    = 1'b0;
   assign rsp_err      = 1'b0;
   assign unused_range = addr_oob;
`endif

   assign req_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE) || req_valid;
   assign rsp_valid = (state_q == ST_DONE);
   // Low byte of a load arrives during DONE, so the result is shown live then and held afterwards
   assign rsp_rdata = rsp_valid ? done_rdata : rdata_q;

   // Assemble the completed load result; faults and stores report zero
   always_comb begin
      if (err_q || write_q) begin
         done_rdata = '0;
      end else if (word_q) begin
         done_rdata = {hi_q, mem_rdata};
      end else begin
         done_rdata = {{BYTE_W{1'b0}}, mem_rdata};
      end
   end

   // Next-state sequencing: latch the request, walk the byte phases, capture results
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      write_d = write_q;
      word_d  = word_q;
      err_d   = err_q;
      hi_d    = hi_q;
      rdata_d = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               write_d = req_write;
               word_d  = req_word;
               err_d   = req_fault;
               state_d = req_fault ? ST_DONE : ST_HI;
            end
         end
         ST_HI: begin
            state_d = word_q ? ST_LO : ST_DONE;
         end
         ST_LO: begin
            if (!write_q) begin
               hi_d = mem_rdata;
            end
            state_d = ST_DONE;
         end
         ST_DONE: begin
            rdata_d = done_rdata;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Memory strobes come from the current state only; quiet in IDLE and DONE
   always_comb begin
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         ST_HI: begin
            mem_re   = !write_q;
            mem_we   = write_q;
            mem_addr = addr_q;
            if (write_q) begin
               mem_wdata = word_q ? wdata_q[WORD_W-1:BYTE_W] : wdata_q[BYTE_W-1:0];
            end
         end
         ST_LO: begin
            mem_re   = !write_q;
            mem_we   = write_q;
            mem_addr = addr_inc;
            if (write_q) begin
               mem_wdata = wdata_q[BYTE_W-1:0];
            end
         end
         default: begin
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
         word_q  <= 1'b0;
         err_q   <= 1'b0;
         hi_q    <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
         word_q  <= word_d;
         err_q   <= err_d;
         hi_q    <= hi_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - scoreboard bench for mem_stage_lsu with a byte memory model
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic        req_word = 1'b0;
   logic [15:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;
   logic [15:0] mem_addr;
   logic        mem_re;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   typedef struct {
      logic [15:0] rdata;
      logic        err;
      int          lat;
      int          acc;
   } exp_t;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
   } wr_t;

   exp_t        sb_q[$];
   wr_t         wr_log[$];
   logic [15:0] re_log[$];
   logic [7:0]  mem_arr [0:65535];

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   bit          have_last = 1'b0;
   logic [15:0] last_rdata = '0;

   mem_stage_lsu #(.N(100), .AW(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_word  (req_word),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .mem_addr  (mem_addr),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Byte memory: writes at the edge, read data one cycle after mem_re
   initial begin
      wr_t w;
      for (int i = 0; i < 65536; i++) mem_arr[i] = 8'h00;
      mem_arr[16'h0000] = 8'h3C;
      mem_arr[16'h0001] = 8'hAD;
      mem_arr[16'h0007] = 8'hED;
      mem_arr[16'hFFFF] = 8'h5A;
      mem_rdata <= 8'h00;
      forever begin
         @(posedge clk);
         if (mem_we) begin
            mem_arr[mem_addr] = mem_wdata;
            w.addr = mem_addr;
            w.data = mem_wdata;
            wr_log.push_back(w);
         end
         if (mem_re) begin
            mem_rdata <= mem_arr[mem_addr];
            re_log.push_back(mem_addr);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every response and checks data, error, latency
   always @(negedge clk) begin
      exp_t e;
      checks++;
      if (mem_re && mem_we) begin
         errors++;
         $display("FAIL strobe_excl: mem_re and mem_we both high at cycle %0d", cyc);
      end
      if (rsp_valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: rsp_valid with rdata 0x%0h at cycle %0d, none expected", rsp_rdata, cyc);
         end else begin
            e = sb_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_latency", cyc - e.acc, e.lat);
            chk("done_strobes", {mem_re, mem_we}, 2'b00);
         end
         last_rdata = rsp_rdata;
         have_last  = 1'b1;
      end else if (have_last) begin
         chk("rdata_hold", rsp_rdata, last_rdata);
      end
   end

   task automatic issue(input logic wr, input logic wd, input logic [15:0] a, input logic [15:0] wdat,
                        input logic [15:0] erd, input logic eerr, input int elat);
      exp_t e;
      bit   got;
      @(negedge clk);
      wr_log.delete();
      re_log.delete();
      req_write = wr;
      req_word  = wd;
      req_addr  = a;
      req_wdata = wdat;
      req_valid = 1'b1;
      got = 1'b0;
      for (int t = 0; t < 20; t++) begin
         #1;
         if (req_ready) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (got) begin
         chk("busy_on_valid", busy, 1'b1);
         e.rdata = erd;
         e.err   = eerr;
         e.lat   = elat;
         e.acc   = cyc;
         sb_q.push_back(e);
      end else begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: req_ready stayed %0b for addr 0x%0h", req_ready, a);
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit ok;
      ok = 1'b0;
      for (int t = 0; t < 20; t++) begin
         if (sb_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL rsp_timeout: %0d responses still pending", sb_q.size());
         sb_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_err", rsp_err, 1'b0);
      chk("rst_rsp_rdata", rsp_rdata, 16'h0000);
      chk("rst_mem_re", mem_re, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 16'h0000);
      chk("rst_mem_wdata", mem_wdata, 8'h00);
      rst = 1'b1;

      // Word load, big-endian assembly
      issue(1'b0, 1'b1, 16'h0000, 16'h0000, 16'h3CAD, 1'b0, 3);
      wait_done();
      chk("wl0_re_cnt", re_log.size(), 2);
      if (re_log.size() == 2) begin
         chk("wl0_re_addr0", re_log[0], 16'h0000);
         chk("wl0_re_addr1", re_log[1], 16'h0001);
      end

      // Word store, high byte first
      issue(1'b1, 1'b1, 16'h0004, 16'h1463, 16'h0000, 1'b0, 3);
      wait_done();
      chk("ws_wr_cnt", wr_log.size(), 2);
      chk("ws_re_cnt", re_log.size(), 0);
      if (wr_log.size() == 2) begin
         chk("ws_wr0_addr", wr_log[0].addr, 16'h0004);
         chk("ws_wr0_data", wr_log[0].data, 8'h14);
         chk("ws_wr1_addr", wr_log[1].addr, 16'h0005);
         chk("ws_wr1_data", wr_log[1].data, 8'h63);
      end

      // Read back the stored word
      issue(1'b0, 1'b1, 16'h0004, 16'h0000, 16'h1463, 1'b0, 3);
      wait_done();

      // Byte load, zero-extended, single strobe
      issue(1'b0, 1'b0, 16'h0007, 16'h0000, 16'h00ED, 1'b0, 2);
      wait_done();
      chk("bl_re_cnt", re_log.size(), 1);
      if (re_log.size() == 1) chk("bl_re_addr", re_log[0], 16'h0007);

`ifdef LSU_RANGE_CHECK_EN
      // Word whose second byte is out of range faults without touching memory
      issue(1'b0, 1'b1, 16'd99, 16'h0000, 16'h0000, 1'b1, 1);
      wait_done();
      chk("oob_re_cnt", re_log.size(), 0);
`else
      // Word load at the top of the address space wraps to 0x0000
      issue(1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h5A3C, 1'b0, 3);
      wait_done();
      chk("wrap_re_cnt", re_log.size(), 2);
      if (re_log.size() == 2) begin
         chk("wrap_re_addr0", re_log[0], 16'hFFFF);
         chk("wrap_re_addr1", re_log[1], 16'h0000);
      end
`endif

      // Byte store uses the low data byte only
      issue(1'b1, 1'b0, 16'h0010, 16'h77AB, 16'h0000, 1'b0, 2);
      wait_done();
      chk("bs_wr_cnt", wr_log.size(), 1);
      if (wr_log.size() == 1) begin
         chk("bs_wr_addr", wr_log[0].addr, 16'h0010);
         chk("bs_wr_data", wr_log[0].data, 8'hAB);
      end
      issue(1'b0, 1'b0, 16'h0010, 16'h0000, 16'h00AB, 1'b0, 2);
      wait_done();

      // Reset during the LO phase of a word store abandons it silently
      @(negedge clk);
      have_last = 1'b0;
      req_write = 1'b1;
      req_word  = 1'b1;
      req_addr  = 16'h0020;
      req_wdata = 16'hBEEF;
      req_valid = 1'b1;
      #1;
      chk("rs_ready_before", req_ready, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      #1;
      chk("rs_lo_we", mem_we, 1'b1);
      chk("rs_lo_addr", mem_addr, 16'h0021);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rs_ready_after", req_ready, 1'b1);
      chk("rs_busy_after", busy, 1'b0);
      chk("rs_rdata_after", rsp_rdata, 16'h0000);
      @(negedge clk);
      #1;
      chk("rs_ready_next", req_ready, 1'b1);
      chk("rs_rsp_valid", rsp_valid, 1'b0);
      chk("rs_hi_kept", mem_arr[16'h0020], 8'hBE);

      // Normal operation resumes after reset
      issue(1'b0, 1'b1, 16'h0000, 16'h0000, 16'h3CAD, 1'b0, 3);
      wait_done();

      repeat (3) @(negedge clk);
      chk("sb_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
